rs_cw_assembler: RTL and testbench
==================================

# rs_cw_assembler

Streaming Reed-Solomon codeword assembler for the 1.6T AUI transmit path. It sits between the AM-mapped scrambled flows and the RS(544,514) encoder. It accepts narrow per-flow symbol beats over a valid/ready handshake and distributes each flow's symbols round-robin into `CW_PER_FLOW` codewords. Once every codeword holds `K_SYMS` message symbols, it presents all codewords at once, with the parity field pre-filled, behind a one-deep output register.

## Interface
- `NUM_FLOWS`, 2: number of input flows.
- `CW_PER_FLOW`, 2: codewords interleaved per flow.
- `SYM_BITS`, 10: RS symbol width.
- `N_SYMS`, 544: codeword length in symbols.
- `K_SYMS`, 514: message symbols per codeword.
- `BEAT_SYMS`, 4: symbols per flow per beat. `CW_PER_FLOW*K_SYMS` must be divisible by `BEAT_SYMS`; violation is an elaboration error.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_sof`  in  1  beat is the first beat of a block.
- `in_data`  in  `NUM_FLOWS*BEAT_SYMS*SYM_BITS`  flow f, symbol j at `[(f*BEAT_SYMS+j)*SYM_BITS +: SYM_BITS]`; j=0 is earliest in stream order.
- `out_valid`  out  1  codeword set valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `NUM_FLOWS*CW_PER_FLOW*N_SYMS*SYM_BITS`  codeword c=f*CW_PER_FLOW+w at `[c*N_SYMS*SYM_BITS +: N_SYMS*SYM_BITS]`.
- `err_realign`  out  1  one-cycle pulse when a partial block is dropped.
- `blk_cnt`  out  16  blocks emitted, wraps at 2^16.

## Operation
- `BEATS = CW_PER_FLOW*K_SYMS/BEAT_SYMS`. With defaults this is 257.
- Within flow f, stream symbol s goes to codeword w = s mod `CW_PER_FLOW`, at position p = s div `CW_PER_FLOW`.
- Position p occupies codeword bits `[(N_SYMS-p)*SYM_BITS-1 -: SYM_BITS]`, so p=0 is at the MSB.
- Parity field is `[(N_SYMS-K_SYMS)*SYM_BITS-1:0]`; see Configuration for its contents.
- FSM has two states, ALIGN and FILL, plus a beat counter `bcnt` over 0..BEATS-1.
- ALIGN:
  - `in_ready` is 1.
  - Beats with `in_sof`=0 are discarded.
  - An accepted beat with `in_sof`=1 is stored as beat 0, sets `bcnt`=1, and moves to FILL.
- FILL:
  - Each accepted beat writes its symbols into the accumulator and increments `bcnt`.
  - The beat with `bcnt`=BEATS-1 is the final beat. On acceptance, accumulator plus final beat load `out_data`, `out_valid` is set, `blk_cnt` increments, `bcnt` returns to 0, and the FSM stays in FILL.
  - The next block's first beat needs no `in_sof`.
- `in_sof`=1 on an accepted FILL beat with `bcnt`≠0: drop the partial block, pulse `err_realign`, and treat the beat as beat 0 (`bcnt`=1).
  - `in_sof`=1 with `bcnt`=0 is normal.
- In FILL, `in_ready = (bcnt != BEATS-1) || !out_valid || out_ready`. Non-final beats are never back-pressured.
- `out_valid` clears on `out_valid && out_ready` unless a new set loads in the same cycle. If a set loads in that cycle, `out_valid` stays 1 with the new data.
- `out_data` is stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `err_realign`=0, `blk_cnt`=0.
  - FSM=ALIGN, `bcnt`=0, accumulator=0.
- Reset mid-block discards all partial and pending data.
- Latency: `out_valid` rises in the cycle after the final beat is accepted.
- Throughput: one beat per cycle sustained when `out_ready`=1.
- `in_ready` depends combinationally on `out_ready` and `out_valid` only. There is no path from `in_valid`.

## Configuration
- `RS_PARITY_MARK_EN` defined: the parity field of codeword c is the 2-bit value (c mod 4), replicated and truncated to the field width. With defaults, codeword 0 is all 0s and codeword 3 is `{150{2'b11}}`. Use this for lane-tracing in simulation.
- `RS_PARITY_MARK_EN` undefined: the parity field is all zeros.

## Structure
- Package `rs_pkg` contains:
  - `SYM_BITS`, `N_SYMS`, `K_SYMS` constants.
  - `sym_t` typedef (logic [SYM_BITS-1:0]).
  - State enum `rs_asm_state_e`.
  - Function `parity_fill(c)`.
- Sub-module `rs_flow_distributor` is instantiated once per flow. It maps a beat's `BEAT_SYMS` symbols, plus `bcnt`, to codeword/position write enables into that flow's accumulator slice.
- The top level holds the FSM, `bcnt`, output register and `blk_cnt`.

## Test plan
- **Single block:** defaults; sof on beat 0; flow 0 symbol s = s mod 1024, flow 1 = 512+s. Send 257 beats with `out_ready`=1.
  - `out_valid` rises 1 cycle after beat 256.
  - cw0 bits `[5439:5430]`=0, cw1 `[5439:5430]`=1, cw2 `[5439:5430]`=512.
  - cw1 position 513 = 1027 mod 1024 = 3.
  - `blk_cnt`=1.
- **Back-pressure:** hold `out_ready`=0 across 2 blocks.
  - Second block's final beat stalls with `in_ready`=0; first `out_data` stays stable.
  - Raise `out_ready`: the new set loads in the same cycle; `out_valid` stays 1.
- **Realign:** `in_sof` on the 100th beat.
  - `err_realign` pulses once.
  - The next set emits 257 beats later and contains only post-realign data.
- **Alignment:** 10 beats without sof after reset.
  - All are accepted and discarded; `out_valid` never rises until 257 beats after the first sof.
- **Reset mid-block:** reset at beat 128.
  - Outputs return to reset values; the following full block emits correct data.
- **Parity fill:** with `RS_PARITY_MARK_EN`, cw2 bits `[299:0]` = `{150{2'b10}}`; without it, all four parity fields are 0.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants, types and parity-field helper for the RS codeword assembler.
// RS_PARITY_MARK_EN: fill parity fields with a per-codeword lane-trace mark.
package rs_pkg;

    localparam int SYM_BITS = 10;
    localparam int N_SYMS   = 544;
    localparam int K_SYMS   = 514;
    localparam int PAR_BITS = (N_SYMS - K_SYMS) * SYM_BITS;

`ifdef RS_PARITY_MARK_EN
    localparam bit PARITY_MARK = 1'b1;
`else
    localparam bit PARITY_MARK = 1'b0;
`endif

    typedef logic [SYM_BITS-1:0] sym_t;

    typedef enum logic {
        ALIGN,
        FILL
    } rs_asm_state_e;

    // Parity field for codeword c: (c mod 4) replicated from the LSB up, or zero.
    function automatic logic [PAR_BITS-1:0] parity_fill(input int c);
        logic [PAR_BITS-1:0] r;
        logic [1:0]          mark;
        mark = PARITY_MARK ? 2'(c % 4) : 2'b00;
        for (int i = 0; i < PAR_BITS; i++) begin
            r[i] = (i % 2 == 0) ? mark[0] : mark[1];
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_flow_distributor.sv
// Per-flow accumulator: scatters one beat of stream symbols round-robin across
// CW_PER_FLOW codewords and exposes the accumulator merged with the current beat.
module rs_flow_distributor #(
    parameter int  CW_PER_FLOW = 2,
    parameter int  K_SYMS      = 514,
    parameter int  SYM_BITS    = 10,
    parameter int  BEAT_SYMS   = 4,
    localparam int BEATS       = CW_PER_FLOW * K_SYMS / BEAT_SYMS,
    localparam int BW          = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             wr,
    input  logic [BW-1:0]                                    bidx,
    input  logic [BEAT_SYMS*SYM_BITS-1:0]                    syms,
    output logic [CW_PER_FLOW-1:0][K_SYMS-1:0][SYM_BITS-1:0] merged
);

    localparam int SW = $clog2(CW_PER_FLOW * K_SYMS) + 1;
    localparam int WW = (CW_PER_FLOW > 1) ? $clog2(CW_PER_FLOW) : 1;
    localparam int PW = (K_SYMS > 1) ? $clog2(K_SYMS) : 1;

    logic [SW-1:0] sidx [BEAT_SYMS];
    logic [WW-1:0] wsel [BEAT_SYMS];
    logic [PW-1:0] psel [BEAT_SYMS];

    logic [CW_PER_FLOW-1:0][K_SYMS-1:0][SYM_BITS-1:0] acc;

    // Stream symbol s lands in codeword s mod CW_PER_FLOW at position s div CW_PER_FLOW.
    always_comb begin
        for (int j = 0; j < BEAT_SYMS; j++) begin
            sidx[j] = SW'(bidx) * SW'(BEAT_SYMS) + SW'(j);
            wsel[j] = WW'(sidx[j] % SW'(CW_PER_FLOW));
            psel[j] = PW'(sidx[j] / SW'(CW_PER_FLOW));
        end
    end

    always_comb begin
        merged = acc;
        for (int j = 0; j < BEAT_SYMS; j++) begin
            merged[wsel[j]][psel[j]] = syms[j*SYM_BITS +: SYM_BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (wr) begin
            for (int j = 0; j < BEAT_SYMS; j++) begin
                acc[wsel[j]][psel[j]] <= syms[j*SYM_BITS +: SYM_BITS];
            end
        end
    end

endmodule

// File: rtl/rs_cw_assembler.sv
// Streaming RS(544,514) codeword assembler: beat alignment FSM, per-flow distributors,
// one-deep output register. RS_PARITY_MARK_EN selects lane-trace parity fill.
module rs_cw_assembler import rs_pkg::*; #(
    parameter int NUM_FLOWS   = 2,
    parameter int CW_PER_FLOW = 2,
    parameter int SYM_BITS    = rs_pkg::SYM_BITS,
    parameter int N_SYMS      = rs_pkg::N_SYMS,
    parameter int K_SYMS      = rs_pkg::K_SYMS,
    parameter int BEAT_SYMS   = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic                                              in_sof,
    input  logic [NUM_FLOWS*BEAT_SYMS*SYM_BITS-1:0]           in_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [NUM_FLOWS*CW_PER_FLOW*N_SYMS*SYM_BITS-1:0]  out_data,
    output logic                                              err_realign,
    output logic [15:0]                                       blk_cnt
);

    localparam int BEATS = CW_PER_FLOW * K_SYMS / BEAT_SYMS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NCW   = NUM_FLOWS * CW_PER_FLOW;
    localparam int CWB   = N_SYMS * SYM_BITS;
    localparam int PW    = (N_SYMS - K_SYMS) * SYM_BITS;

    if ((CW_PER_FLOW * K_SYMS) % BEAT_SYMS != 0) begin : g_bad_beat
        $error("CW_PER_FLOW*K_SYMS must be divisible by BEAT_SYMS");
    end

    rs_asm_state_e state, state_n;
    logic [BW-1:0] bcnt, bcnt_n, bidx;
    logic          accept, final_slot, wr, beat0, load, realign;

    logic [NUM_FLOWS-1:0][CW_PER_FLOW-1:0][K_SYMS-1:0][SYM_BITS-1:0] merged;
    logic [NCW*CWB-1:0] load_data;

    assign final_slot = (bcnt == BW'(BEATS - 1));
    // Only the final beat can stall, and only while an unaccepted set is still held.
    assign in_ready   = (state == ALIGN) || !final_slot || !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign bidx       = beat0 ? '0 : bcnt;

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        wr      = 1'b0;
        beat0   = 1'b0;
        load    = 1'b0;
        realign = 1'b0;
        case (state)
            ALIGN: begin
                if (accept && in_sof) begin
                    wr      = 1'b1;
                    beat0   = 1'b1;
                    bcnt_n  = BW'(1);
                    state_n = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wr = 1'b1;
                    if (in_sof && bcnt != '0) begin
                        realign = 1'b1;
                        beat0   = 1'b1;
                        bcnt_n  = BW'(1);
                    end else if (final_slot) begin
                        load   = 1'b1;
                        bcnt_n = '0;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
            end
            default: state_n = ALIGN;
        endcase
    end

    for (genvar f = 0; f < NUM_FLOWS; f++) begin : g_flow
        rs_flow_distributor #(
            .CW_PER_FLOW (CW_PER_FLOW),
            .K_SYMS      (K_SYMS),
            .SYM_BITS    (SYM_BITS),
            .BEAT_SYMS   (BEAT_SYMS)
        ) u_dist (
            .clk    (clk),
            .rst    (rst),
            .wr     (wr),
            .bidx   (bidx),
            .syms   (in_data[f*BEAT_SYMS*SYM_BITS +: BEAT_SYMS*SYM_BITS]),
            .merged (merged[f])
        );

        for (genvar w = 0; w < CW_PER_FLOW; w++) begin : g_cw
            localparam int C = f * CW_PER_FLOW + w;
            // Position 0 sits at the codeword MSB; parity occupies the low bits.
            for (genvar p = 0; p < K_SYMS; p++) begin : g_pos
                assign load_data[C*CWB + (N_SYMS-p)*SYM_BITS - 1 -: SYM_BITS] = merged[f][w][p];
            end
            assign load_data[C*CWB +: PW] = PW'(parity_fill(C));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ALIGN;
            bcnt        <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_realign <= 1'b0;
            blk_cnt     <= '0;
        end else begin
            state       <= state_n;
            bcnt        <= bcnt_n;
            err_realign <= realign;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                blk_cnt   <= blk_cnt + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_cw_assembler.sv
// Self-checking bench for rs_cw_assembler: randomized blocks against a symbol-array model.
module tb_rs_cw_assembler;
    import rs_pkg::*;

    localparam int NF = 2, CW = 2, SB = 10, N = 544, K = 514, B = 4;
    localparam int BEATS = CW * K / B;
    localparam int NCW = NF * CW, CWB = N * SB, OW = NCW * CWB, PW = (N - K) * SB, IW = NF * B * SB;
`ifdef RS_PARITY_MARK_EN
    localparam bit MARK = 1'b1;
`else
    localparam bit MARK = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, err_realign;
    logic [IW-1:0] in_data = '0;
    logic [OW-1:0] out_data;
    logic [15:0]   blk_cnt;

    int errors = 0, checks = 0;
    sym_t sym_mem [NF][CW*K];
    logic [OW-1:0] exp_v, held_v;

    always #5 clk = ~clk;

    rs_cw_assembler dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_realign(err_realign), .blk_cnt(blk_cnt)
    );

    // Expected codeword set from the recorded per-flow symbol streams.
    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] v = '0;
        for (int c = 0; c < NCW; c++) begin
            int f = c / CW, w = c % CW;
            for (int p = 0; p < K; p++) v[c*CWB + (N-p)*SB - 1 -: SB] = sym_mem[f][p*CW + w];
            for (int i = 0; i < PW; i++) v[c*CWB + i] = MARK ? 1'(((c % 4) >> (i % 2)) & 1) : 1'b0;
        end
        return v;
    endfunction

    function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
        for (int k = 0; k < OW / SB; k++) if (a[k*SB +: SB] !== b[k*SB +: SB]) return k;
        return 0;
    endfunction

    task automatic set_beat(input bit sof, input int mode, input int bidx, input bit rec);
        for (int f = 0; f < NF; f++) begin
            for (int j = 0; j < B; j++) begin
                int s = bidx * B + j;
                sym_t v;
                if (mode == 0) v = sym_t'((f == 0) ? s % 1024 : (512 + s) % 1024);
                else           v = sym_t'($urandom_range(0, 1023));
                in_data[(f*B + j)*SB +: SB] = v;
                if (rec) sym_mem[f][s] = v;
            end
        end
        in_sof = sof;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int waits);
        bit done = 1'b0;
        waits = 0;
        while (!done && waits < 1000) begin
            #1;
            if (in_ready) done = 1'b1; else waits++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL accept_timeout: in_ready low %0d cycles, want 1", waits); end
    endtask

    task automatic send_block(input bit sof0, input int mode, output int stalls, output int early);
        int w;
        stalls = 0;
        early = 0;
        for (int b = 0; b < BEATS; b++) begin
            set_beat(sof0 && b == 0, mode, b, 1'b1);
            wait_accept(w);
            stalls += w;
            if (b < BEATS - 1 && out_valid) early++;
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: nonzero, want 0"); end
        checks++; if (err_realign !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err_realign); end
        checks++; if (blk_cnt !== 16'd0) begin errors++; $display("FAIL rst_blk_cnt: got %0d want 0", blk_cnt); end
    endtask

    task automatic test_single_block();
        int st, early, k;
        do_reset();
        send_block(1'b1, 0, st, early);
        exp_v = model_out();
        checks++; if (early != 0 || st != 0) begin errors++; $display("FAIL single_timing: early=%0d stalls=%0d want 0/0", early, st); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_data[5439 -: 10] !== 10'd0) begin errors++; $display("FAIL cw0_p0: got %0d want 0", out_data[5439 -: 10]); end
        checks++; if (out_data[CWB + 5439 -: 10] !== 10'd1) begin errors++; $display("FAIL cw1_p0: got %0d want 1", out_data[CWB + 5439 -: 10]); end
        checks++; if (out_data[2*CWB + 5439 -: 10] !== 10'd512) begin errors++; $display("FAIL cw2_p0: got %0d want 512", out_data[2*CWB + 5439 -: 10]); end
        checks++; if (out_data[CWB + 309 -: 10] !== 10'd3) begin errors++; $display("FAIL cw1_p513: got %0d want 3", out_data[CWB + 309 -: 10]); end
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL single_blk_cnt: got %0d want 1", blk_cnt); end
        checks++;
        if (out_data !== exp_v) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL single_data: sym %0d got %0d want %0d", k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int st1, st2, e1, e2, k;
        do_reset();
        send_block(1'b1, 1, st1, e1);
        exp_v = model_out();
        checks++;
        if (out_data !== exp_v || out_valid !== 1'b1) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL b2b_first: valid=%b sym %0d got %0d want %0d", out_valid, k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        send_block(1'b0, 1, st2, e2);
        exp_v = model_out();
        checks++; if (st1 + st2 != 0 || e2 != 0) begin errors++; $display("FAIL b2b_throughput: stalls=%0d early=%0d want 0/0", st1 + st2, e2); end
        checks++;
        if (out_data !== exp_v || out_valid !== 1'b1) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL b2b_second: valid=%b sym %0d got %0d want %0d", out_valid, k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL b2b_blk_cnt: got %0d want 2", blk_cnt); end
    endtask

    task automatic test_back_pressure();
        int st, early, w, unstable, stalled, k;
        do_reset();
        out_ready = 1'b0;
        send_block(1'b1, 1, st, early);
        held_v = model_out();
        unstable = 0;
        for (int b = 0; b < BEATS - 1; b++) begin
            set_beat(1'b0, 1, b, 1'b1);
            wait_accept(w);
            st += w;
            if (out_data !== held_v || out_valid !== 1'b1) unstable++;
        end
        set_beat(1'b0, 1, BEATS - 1, 1'b1);
        exp_v = model_out();
        stalled = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (!in_ready) stalled++;
            if (out_data !== held_v) unstable++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (st != 0) begin errors++; $display("FAIL bp_nonfinal_stall: got %0d stalls want 0", st); end
        checks++; if (stalled != 3) begin errors++; $display("FAIL bp_final_stall: stalled %0d cycles want 3", stalled); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_hold: %0d unstable samples want 0", unstable); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_kept: got %b want 1", out_valid); end
        checks++;
        if (out_data !== exp_v) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL bp_new_data: sym %0d got %0d want %0d", k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        checks++; if (blk_cnt !== 16'd2) begin errors++; $display("FAIL bp_blk_cnt: got %0d want 2", blk_cnt); end
    endtask

    task automatic test_realign();
        int w, pulses, early, k;
        do_reset();
        for (int b = 0; b < 99; b++) begin
            set_beat(b == 0, 1, b, 1'b0);
            wait_accept(w);
        end
        set_beat(1'b1, 1, 0, 1'b1);
        wait_accept(w);
        checks++; if (err_realign !== 1'b1) begin errors++; $display("FAIL realign_pulse: got %b want 1", err_realign); end
        pulses = 0;
        early = 0;
        for (int b = 1; b < BEATS; b++) begin
            set_beat(1'b0, 1, b, 1'b1);
            wait_accept(w);
            if (err_realign) pulses++;
            if (b < BEATS - 1 && out_valid) early++;
        end
        in_valid = 1'b0;
        exp_v = model_out();
        checks++; if (pulses != 0) begin errors++; $display("FAIL realign_extra: got %0d extra pulses want 0", pulses); end
        checks++; if (early != 0 || out_valid !== 1'b1) begin errors++; $display("FAIL realign_timing: early=%0d valid=%b want 0/1", early, out_valid); end
        checks++;
        if (out_data !== exp_v) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL realign_data: sym %0d got %0d want %0d", k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL realign_blk_cnt: got %0d want 1", blk_cnt); end
    endtask

    task automatic test_alignment();
        int w, st, early, k;
        do_reset();
        st = 0;
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b0, 1, 0, 1'b0);
            wait_accept(w);
            st += w;
        end
        in_valid = 1'b0;
        checks++; if (st != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL align_discard: stalls=%0d valid=%b want 0/0", st, out_valid); end
        send_block(1'b1, 1, st, early);
        exp_v = model_out();
        checks++; if (early != 0 || out_valid !== 1'b1) begin errors++; $display("FAIL align_timing: early=%0d valid=%b want 0/1", early, out_valid); end
        checks++;
        if (out_data !== exp_v) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL align_data: sym %0d got %0d want %0d", k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
    endtask

    task automatic test_reset_mid_block();
        int w, st, early, k;
        do_reset();
        out_ready = 1'b0;
        send_block(1'b1, 1, st, early);
        for (int b = 0; b < 128; b++) begin
            set_beat(1'b0, 1, b, 1'b0);
            wait_accept(w);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || blk_cnt !== 16'd0 || in_ready !== 1'b1 || err_realign !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state: valid=%b data_zero=%b blk=%0d ready=%b err=%b want 0/1/0/1/0",
                     out_valid, out_data == '0, blk_cnt, in_ready, err_realign);
        end
        out_ready = 1'b1;
        send_block(1'b1, 1, st, early);
        exp_v = model_out();
        checks++;
        if (out_data !== exp_v || out_valid !== 1'b1) begin
            errors++; k = first_diff(out_data, exp_v);
            $display("FAIL midrst_data: valid=%b sym %0d got %0d want %0d", out_valid, k, out_data[k*SB +: SB], exp_v[k*SB +: SB]);
        end
        checks++; if (blk_cnt !== 16'd1) begin errors++; $display("FAIL midrst_blk_cnt: got %0d want 1", blk_cnt); end
    endtask

    task automatic test_parity();
        int st, early;
        logic [PW-1:0] want, want2;
        do_reset();
        send_block(1'b1, 1, st, early);
        for (int c = 0; c < NCW; c++) begin
            for (int i = 0; i < PW; i++) want[i] = MARK ? 1'(((c % 4) >> (i % 2)) & 1) : 1'b0;
            checks++;
            if (out_data[c*CWB +: PW] !== want) begin
                errors++;
                $display("FAIL parity_cw%0d: low bits got %0h want %0h", c, out_data[c*CWB +: 8], want[7:0]);
            end
        end
        want2 = MARK ? {150{2'b10}} : '0;
        checks++;
        if (out_data[2*CWB +: PW] !== want2) begin
            errors++; $display("FAIL parity_cw2_pattern: low bits got %0h want %0h", out_data[2*CWB +: 8], want2[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_back_pressure();
        test_realign();
        test_alignment();
        test_reset_mid_block();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
